// File: rtl/sha256_stream_hasher.sv
// sha256_stream_hasher
//   SHA-256 engine for a message of NUM_OF_WORDS 32-bit words held in a
//   word-addressed memory. FIPS 180-4 padding is generated on the fly while
//   the blocks are loaded. The 256-bit digest is written back as eight words.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   start                  one-cycle request, only looked at in IDLE
//   message_addr           word address of message word 0 (latched on start)
//   output_addr            word address for digest word H0 (latched on start)
//   busy                   high while a hash is in progress
//   done                   one-cycle pulse after the digest has been written
//   mem_clk                copy of clk for the memory
//   mem_we, mem_addr,
//   mem_write_data         memory write/address port
//   mem_read_data          read data, valid the cycle after its address
module sha256_stream_hasher #(
  parameter int NUM_OF_WORDS = 20,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] message_addr,
  input  logic [ADDR_WIDTH-1:0] output_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_clk,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  localparam int NUM_BLOCKS = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam int BLK_W      = $clog2(NUM_BLOCKS + 1);

  localparam logic [31:0] MSG_WORDS    = 32'(NUM_OF_WORDS);
  localparam logic [31:0] MSG_LEN_BITS = 32'(NUM_OF_WORDS * 32);
  localparam logic [31:0] LAST_WORD    = 32'(NUM_BLOCKS * 16 - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] COMPUTE = 3'd2;
  localparam logic [2:0] UPDATE  = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] FINISH  = 3'd5;

  localparam logic [31:0] H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Padding word for a padded index at or beyond the message end. The upper
  // length word is always zero in the legal length range, so it falls to 0.
  function automatic logic [31:0] pad_value(input logic [31:0] idx);
    if (idx == MSG_WORDS)      return 32'h80000000;
    else if (idx == LAST_WORD) return MSG_LEN_BITS;
    else                       return 32'h0;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [BLK_W-1:0]      blk_q, blk_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] msg_base_q, msg_base_d;
  logic [ADDR_WIDTH-1:0] out_base_q, out_base_d;
  logic [31:0]           h_q [0:7];
  logic [31:0]           h_d [0:7];
  logic [31:0]           v_q [0:7];
  logic [31:0]           v_d [0:7];
  logic [31:0]           w_q [0:15];
  logic [31:0]           w_d [0:15];

  logic [31:0] addr_idx;
  logic [31:0] cap_idx;
  logic [31:0] cap_word;
  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] w_new;

  // Padded word indices: the one being addressed this cycle, and the one
  // whose data arrives this cycle (addressed one cycle earlier).
  always_comb begin
    addr_idx = 32'(blk_q) * 32'd16 + 32'(cnt_q[3:0]);
    cap_idx  = 32'(blk_q) * 32'd16 + 32'(cnt_q) - 32'd1;
    cap_word = (cap_idx < MSG_WORDS) ? mem_read_data : pad_value(cap_idx);
  end

  // One compression round. The W window always holds W[t..t+15], so W[t] is
  // the oldest entry and the word shifted in is W[t+16]. The last 16 rounds
  // produce words that are never used, which keeps the schedule uniform.
  always_comb begin
    t1 = v_q[7] + big_sigma1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
         + K[cnt_q[5:0]] + w_q[0];
    t2 = big_sigma0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
  end

  // Next-state logic for the controller and the datapath registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    done_d     = 1'b0;
    msg_base_d = msg_base_q;
    out_base_d = out_base_q;
    h_d        = h_q;
    v_d        = v_q;
    w_d        = w_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          msg_base_d = message_addr;
          out_base_d = output_addr;
          h_d        = H_INIT;
          blk_d      = '0;
          cnt_d      = 7'd0;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        if (cnt_q != 7'd0) begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
          w_d[15] = cap_word;
        end
        if (cnt_q == 7'd16) begin
          v_d     = h_q;
          cnt_d   = 7'd0;
          state_d = COMPUTE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      COMPUTE: begin
        v_d[0] = t1 + t2;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + t1;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
        w_d[15] = w_new;
        if (cnt_q == 7'd63) begin
          cnt_d   = 7'd0;
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      UPDATE: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        blk_d = blk_q + BLK_W'(1);
        cnt_d = 7'd0;
        if (32'(blk_q) + 32'd1 < 32'(NUM_BLOCKS)) state_d = LOAD;
        else                                      state_d = WRITE;
      end

      WRITE: begin
        if (cnt_q == 7'd7) state_d = FINISH;
        else               cnt_d   = cnt_q + 7'd1;
      end

      FINISH: begin
        // done is registered, so the pulse appears in the IDLE cycle after
        // FINISH; a start in the FINISH cycle itself is not seen.
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control flops; reset aborts any operation and drops the pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 7'd0;
      blk_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      done_q  <= done_d;
    end
  end

  // Datapath flops need no reset: they are always loaded before being used.
  always_ff @(posedge clk) begin
    msg_base_q <= msg_base_d;
    out_base_q <= out_base_d;
    h_q        <= h_d;
    v_q        <= v_d;
    w_q        <= w_d;
  end

  // Memory port decode. Address sums wrap naturally at ADDR_WIDTH bits.
  always_comb begin
    mem_addr       = '0;
    mem_write_data = 32'h0;
    mem_we         = 1'b0;
    if (state_q == LOAD && cnt_q < 7'd16) begin
      mem_addr = msg_base_q + ADDR_WIDTH'(addr_idx);
    end else if (state_q == WRITE) begin
      mem_we         = 1'b1;
      mem_addr       = out_base_q + ADDR_WIDTH'(cnt_q);
      mem_write_data = h_q[cnt_q[2:0]];
    end
  end

  assign mem_clk = clk;
  assign done    = done_q;
  assign busy    = (state_q == LOAD) || (state_q == COMPUTE) ||
                   (state_q == UPDATE) || (state_q == WRITE);

endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Testbench for sha256_stream_hasher. Several instances with different
// message lengths share clock and reset; one is exercised at a time. Expected
// digest writes are pushed to a scoreboard queue when a job is started and are
// popped as the active instance writes them.
module tb_sha256_stream_hasher;

  localparam int NI = 7;
  // Message length of each instance; index 0 is the lowest slice.
  localparam logic [NI-1:0][15:0] NS = {16'd30, 16'd29, 16'd16, 16'd14, 16'd13, 16'd20, 16'd1};

  localparam logic [255:0] KAT_ABCD =
    256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NI-1:0]            start_v;
  logic [15:0]              msg_addr;
  logic [15:0]              out_addr;
  logic [NI-1:0]            busy_v, done_v, we_v, mclk_v;
  logic [NI-1:0][15:0]      addr_v;
  logic [NI-1:0][31:0]      wdata_v;

  logic [31:0] mem [NI][65536];
  logic [31:0] msg_buf [4096];
  logic [63:0] exp_q [$];

  int tests_run = 0;
  int failures  = 0;
  int act       = 0;
  int wr_cnt    = 0;
  int done_cnt  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic        mclk, busy, done, we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_data;

    sha256_stream_hasher #(.NUM_OF_WORDS(int'(NS[gi])), .ADDR_WIDTH(16)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start_v[gi]),
      .message_addr   (msg_addr),
      .output_addr    (out_addr),
      .busy           (busy),
      .done           (done),
      .mem_clk        (mclk),
      .mem_we         (we),
      .mem_addr       (addr),
      .mem_write_data (wdata),
      .mem_read_data  (rd_data)
    );

    // Synchronous-read memory: data is valid the cycle after the address.
    always @(posedge clk) rd_data <= mem[gi][addr];

    assign busy_v[gi]  = busy;
    assign done_v[gi]  = done;
    assign we_v[gi]    = we;
    assign mclk_v[gi]  = mclk;
    assign addr_v[gi]  = addr;
    assign wdata_v[gi] = wdata;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] padWord(input int p, input int n, input int nb);
    if (p < n)               return msg_buf[p];
    if (p == n)              return 32'h80000000;
    if (p == nb * 16 - 1)    return 32'(n * 32);
    return 32'h0;
  endfunction

  // Straightforward software SHA-256 over msg_buf[0..n-1].
  function automatic logic [255:0] shaModel(input int n);
    logic [31:0] hv [8];
    logic [31:0] w [64];
    logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, s0, s1, t1, t2;
    int nb;
    nb = (n + 18) / 16;
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int blk = 0; blk < nb; blk++) begin
      for (int t = 0; t < 16; t++) w[t] = padWord(blk * 16 + t, n, nb);
      for (int t = 16; t < 64; t++) begin
        s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      va = hv[0]; vb = hv[1]; vc = hv[2]; vd = hv[3];
      ve = hv[4]; vf = hv[5]; vg = hv[6]; vh = hv[7];
      for (int t = 0; t < 64; t++) begin
        t1 = vh + (rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + KT[t] + w[t];
        t2 = (rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
        vh = vg; vg = vf; vf = ve; ve = vd + t1;
        vd = vc; vc = vb; vb = va; va = t1 + t2;
      end
      hv[0] += va; hv[1] += vb; hv[2] += vc; hv[3] += vd;
      hv[4] += ve; hv[5] += vf; hv[6] += vg; hv[7] += vh;
    end
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  endfunction

  // Write monitor for the active instance: every write must match the next
  // scoreboard entry (address and data).
  always @(negedge clk) begin
    if (we_v[act]) begin
      wr_cnt++;
      if (exp_q.size() == 0) checkOutput("unexpected_write", {32'h0, 16'h0, addr_v[act]}, 64'hFFFF_FFFF_FFFF_FFFF);
      else                   checkOutput("digest_write", {16'h0, addr_v[act], wdata_v[act]}, exp_q.pop_front());
    end
    if (done_v[act]) done_cnt++;
  end

  // Runs one hash job on instance inst. repulse re-asserts start at cycles 5
  // and 100; a nonzero reset_cyc asserts reset in that cycle and ends the job.
  task automatic applyStimulus(input int inst, input logic [15:0] maddr, input logic [15:0] oaddr,
                               input bit kat, input bit repulse, input int reset_cyc);
    int n, nb, k, exp_cycle;
    bit got;
    logic [31:0] val;
    logic [255:0] dg;
    n = int'(NS[inst]);
    nb = (n + 18) / 16;
    exp_cycle = 82 * nb + 10;
    for (int i = 0; i < n; i++) begin
      val = kat ? 32'h61626364 : $urandom;
      mem[inst][maddr + 16'(i)] = val;
      msg_buf[i] = val;
    end
    dg = kat ? KAT_ABCD : shaModel(n);
    for (int i = 0; i < 8; i++)
      exp_q.push_back({16'h0, oaddr + 16'(i), dg[255 - 32*i -: 32]});

    act = inst;
    wr_cnt = 0;
    done_cnt = 0;
    msg_addr = maddr;
    out_addr = oaddr;
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    checkOutput($sformatf("busy_after_start_n%0d", n), 64'(busy_v[inst]), 64'd1);

    k = 1;
    got = 1'b0;
    while (k < 400 && !got) begin
      if (reset_cyc != 0 && k == reset_cyc) begin
        checkOutput("we_in_write3", 64'(we_v[inst]), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_we", 64'(we_v[inst]), 64'd0);
        checkOutput("post_reset_busy", 64'(busy_v[inst]), 64'd0);
        checkOutput("post_reset_done", 64'(done_v[inst]), 64'd0);
        checkOutput("aborted_writes_left", 64'(exp_q.size()), 64'd4);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("aborted_done_pulses", 64'(done_cnt), 64'd0);
        checkOutput("aborted_write_count", 64'(wr_cnt), 64'd4);
        return;
      end
      start_v[inst] = (repulse && (k == 5 || k == 100));
      @(posedge clk); #1;
      k++;
      if (done_v[inst]) got = 1'b1;
    end
    start_v[inst] = 1'b0;

    if (!got) checkOutput($sformatf("done_timeout_n%0d", n), 64'd0, 64'd1);
    else      checkOutput($sformatf("done_cycle_n%0d", n), 64'(k), 64'(exp_cycle));
    checkOutput($sformatf("busy_at_done_n%0d", n), 64'(busy_v[inst]), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput($sformatf("write_count_n%0d", n), 64'(wr_cnt), 64'd8);
    checkOutput($sformatf("done_pulses_n%0d", n), 64'(done_cnt), 64'd1);
    checkOutput($sformatf("queue_drained_n%0d", n), 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start_v = '0;
    msg_addr = 16'h0;
    out_addr = 16'h0;
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 65536; a++) mem[i][a] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy_v), 64'd0);
    checkOutput("reset_done", 64'(done_v), 64'd0);
    checkOutput("reset_we", 64'(we_v), 64'd0);
    checkOutput("reset_addr", 64'(addr_v[0]), 64'd0);
    checkOutput("reset_wdata", 64'(wdata_v[0]), 64'd0);
    checkOutput("mem_clk_high", 64'(mclk_v[0]), 64'd1);
    @(negedge clk);
    checkOutput("mem_clk_low", 64'(mclk_v[0]), 64'd0);
    reset = 1'b0;

    $display("[TB] known answer: N=1 \"abcd\"");
    applyStimulus(0, 16'h0010, 16'h0200, 1'b1, 1'b0, 0);

    $display("[TB] N=20 random, two blocks");
    applyStimulus(1, 16'h0000, 16'h0100, 1'b0, 1'b0, 0);

    $display("[TB] boundary lengths 13, 14, 16, 29, 30");
    for (int i = 2; i < NI; i++)
      applyStimulus(i, 16'h0040, 16'h0300, 1'b0, 1'b0, 0);

    $display("[TB] message address wrap");
    applyStimulus(1, 16'hFFF8, 16'h0500, 1'b0, 1'b0, 0);

    $display("[TB] start re-pulsed while busy");
    applyStimulus(1, 16'h0020, 16'h0600, 1'b0, 1'b1, 0);

    $display("[TB] reset during WRITE cycle 3, then rerun");
    applyStimulus(1, 16'h0080, 16'h0700, 1'b0, 1'b0, 82 * 2 + 1 + 3);
    applyStimulus(1, 16'h0090, 16'h0780, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/sha256_stream_hasher.md
Name: sha256_stream_hasher

Overview:
- Parametrised SHA-256 engine. Hashes a message of NUM_OF_WORDS 32-bit words read from the shared word-addressed testbench memory, and writes the 256-bit digest back to memory.
- Supports any message length. FIPS 180-4 padding is generated internally: block count, 0x80000000 word, zero fill and 64-bit length field.
- Next-generation replacement for the fixed two-block hasher. Uses the same memory port set and start/done protocol.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..4096.
- ADDR_WIDTH, 16, width of all memory address ports.

Ports:
- clk  input  1  system clock; also drives mem_clk.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- message_addr  input  ADDR_WIDTH  word address of message word 0; latched on start.
- output_addr  input  ADDR_WIDTH  word address for digest word H0; latched on start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the digest is fully written.
- mem_clk  output  1  equal to clk.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_WIDTH  memory word address.
- mem_write_data  output  32  memory write data.
- mem_read_data  input  32  read data; valid the cycle after its address is presented.

Behaviour:
- Reset values: busy=0, done=0, mem_we=0, mem_addr=0, mem_write_data=0; state=IDLE.
- Reset mid-operation aborts immediately. Any write in progress is dropped; no done pulse is produced.
- Block count: B = ceil((NUM_OF_WORDS+3)/16), computed at elaboration. Examples: N=1→1, N=13→1, N=14→2, N=20→2.
- Padded word p, for 0 ≤ p < 16B:
  - p<N: memory word at message_addr+p.
  - p==N: 32'h80000000.
  - p==16B-2: upper 32 bits of 32N (always 0 in the legal range).
  - p==16B-1: low 32 bits of 32N.
  - otherwise: 0.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- States: IDLE, LOAD, COMPUTE, UPDATE, WRITE, FINISH.
- IDLE:
  - start=1 latches both addresses and loads H0..H7 with the standard IVs: 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
  - Goes to LOAD with block index 0.
- LOAD (17 cycles per block):
  - Cycles 0..15: present the address of padded word 16b+k.
  - Cycle k+1: capture word k into the 16-entry W window.
  - For padding words (p≥N) the address is still driven, but the captured value is the generated padding word, not mem_read_data.
  - mem_we=0 throughout.
  - On the last cycle, load a..h from H0..H7 and go to COMPUTE.
- COMPUTE (64 cycles, one round per cycle, round t=0..63):
  - Wt = W[t] for t<16. Otherwise Wt = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], computed on the fly from a 16-entry shift window; no 64-entry array.
  - All additions are modulo 2^32.
- UPDATE (1 cycle):
  - Hi += working register i, modulo 2^32.
  - Increment the block index.
  - If the index is below B, go to LOAD; otherwise go to WRITE.
- WRITE (8 cycles):
  - Cycle i: mem_we=1, mem_addr=output_addr+i, mem_write_data=Hi, for i=0..7.
- FINISH (1 cycle):
  - done=1, busy=0, mem_we=0; return to IDLE.
- Latency: start accepted in cycle 0 → done asserted in cycle 82B+10. For N=20 that is cycle 174.
- start while busy is ignored. start in the FINISH cycle is ignored; a new start is accepted from the following IDLE cycle.
- mem_we is never high outside WRITE.

Test Plan:
- N=1, mem[message_addr]=32'h61626364 ("abcd") → digest 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589 written to output_addr..+7; done in cycle 92.
- N=20 with random words; message_addr=0x0000, output_addr=0x0100 → B=2; digest matches the software SHA-256 model; done in cycle 174; exactly 8 cycles with mem_we=1.
- Boundary lengths N=13, 14, 16, 29, 30 → B=1, 2, 2, 2, 3; every digest matches the model; no mem_we outside WRITE.
- message_addr=0xFFF8 with N=20 → reads wrap to 0x0000..0x000B; digest matches the model over the wrapped data.
- start re-pulsed at cycles 5 and 100 of a run → ignored; exactly one digest write; done pulses once.
- reset asserted during WRITE cycle 3 → next cycle mem_we=0, busy=0, done=0; a following start produces a correct digest.
